// File: rtl/byte_serial_add_ctrl_pkg.sv
// Shared definitions for the byte-serial add/subtract sequencer.
package byte_serial_add_ctrl_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int unsigned BYTE_W = 8;

  // Width of the byte index counter; a single-byte operand still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/add_byte_slice.sv
// Combinational 8-bit adder slice with carry in/out and the msb taps used for overflow.
module add_byte_slice
  import byte_serial_add_ctrl_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              cin,
  output logic [BYTE_W-1:0] s,
  output logic              cout,
  output logic              a_msb,
  output logic              b_msb,
  output logic              s_msb
);

  logic [BYTE_W:0] sum;

  always_comb begin
    sum   = {1'b0, a} + {1'b0, b} + {{BYTE_W{1'b0}}, cin};
    s     = sum[BYTE_W-1:0];
    cout  = sum[BYTE_W];
    a_msb = a[BYTE_W-1];
    b_msb = b[BYTE_W-1];
    s_msb = sum[BYTE_W-1];
  end

endmodule

// File: rtl/byte_serial_add_ctrl.sv
// Wide add/subtract sequenced through one 8-bit adder slice, one byte per clock, LSB first.
module byte_serial_add_ctrl
  import byte_serial_add_ctrl_pkg::*;
#(
  parameter  int unsigned NBYTES = 4,
  localparam int unsigned W      = BYTE_W * NBYTES
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         sub,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         cout,
  output logic         ovf,
  output logic         zero
);

  localparam int unsigned IW = idx_width(NBYTES);

  state_t            state;
  logic [W-1:0]      a_q;
  logic [W-1:0]      b_q;
  logic [IW-1:0]     idx;
  logic              carry;
  logic              zacc;
  logic [BYTE_W-1:0] a_byte;
  logic [BYTE_W-1:0] b_byte;
  logic [BYTE_W-1:0] s_byte;
  logic              s_cout;
  logic              a_msb;
  logic              b_msb;
  logic              s_msb;
  logic              last;

  always_comb begin
    a_byte = a_q[idx*BYTE_W +: BYTE_W];
    b_byte = b_q[idx*BYTE_W +: BYTE_W];
    last   = (idx == IW'(NBYTES - 1));
  end

  add_byte_slice u_slice (
    .a     (a_byte),
    .b     (b_byte),
    .cin   (carry),
    .s     (s_byte),
    .cout  (s_cout),
    .a_msb (a_msb),
    .b_msb (b_msb),
    .s_msb (s_msb)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      a_q    <= '0;
      b_q    <= '0;
      idx    <= '0;
      carry  <= 1'b0;
      zacc   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            // Subtraction is A + ~B + 1: invert B once here and seed the carry.
            a_q   <= op_a;
            b_q   <= sub ? ~op_b : op_b;
            carry <= sub;
            idx   <= '0;
            zacc  <= 1'b1;
            busy  <= 1'b1;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          result[idx*BYTE_W +: BYTE_W] <= s_byte;
          carry <= s_cout;
          idx   <= idx + 1'b1;
          zacc  <= zacc & (s_byte == '0);
          if (last) begin
            cout  <= s_cout;
            ovf   <= (a_msb == b_msb) && (s_msb != a_msb);
            zero  <= zacc && (s_byte == '0);
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_byte_serial_add_ctrl.sv
// Self-checking bench: 4-byte and 1-byte instances, vector tables plus handshake/reset corner sequences.
module tb_byte_serial_add_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start4, sub4, busy4, done4, cout4, ovf4, zero4;
  logic [31:0] a4, b4, res4;
  logic        start1, sub1, busy1, done1, cout1, ovf1, zero1;
  logic [7:0]  a1, b1, res1;

  typedef struct {
    logic        sub;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        co;
    logic        ov;
    logic        z;
  } vec_t;

  vec_t q4[$];
  vec_t q1[$];
  vec_t t4[7];
  vec_t t1[3];
  int   nchk  = 0;
  int   nfail = 0;

  always #5 clk = ~clk;

  byte_serial_add_ctrl #(.NBYTES(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .sub(sub4), .op_a(a4), .op_b(b4),
    .busy(busy4), .done(done4), .result(res4), .cout(cout4), .ovf(ovf4), .zero(zero4)
  );

  byte_serial_add_ctrl #(.NBYTES(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .sub(sub1), .op_a(a1), .op_b(b1),
    .busy(busy1), .done(done1), .result(res1), .cout(cout1), .ovf(ovf1), .zero(zero1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge and retire any completed operation against the scoreboard.
  task automatic tick();
    vec_t e;
    @(negedge clk);
    if (done4) begin
      if (q4.size() == 0) chk("done4_unexpected", 32'(done4), 32'd0);
      else begin
        e = q4.pop_front();
        chk("res4", res4, e.r);
        chk("cout4", 32'(cout4), 32'(e.co));
        chk("ovf4", 32'(ovf4), 32'(e.ov));
        chk("zero4", 32'(zero4), 32'(e.z));
      end
    end
    if (done1) begin
      if (q1.size() == 0) chk("done1_unexpected", 32'(done1), 32'd0);
      else begin
        e = q1.pop_front();
        chk("res1", 32'(res1), e.r);
        chk("cout1", 32'(cout1), 32'(e.co));
        chk("ovf1", 32'(ovf1), 32'(e.ov));
        chk("zero1", 32'(zero1), 32'(e.z));
      end
    end
  endtask

  task automatic run_op(input bit one, input vec_t v);
    int nb;
    int cyc;
    int bc;
    nb = one ? 1 : 4;
    tick();
    if (one) begin
      start1 = 1'b1; a1 = v.a[7:0]; b1 = v.b[7:0]; sub1 = v.sub; q1.push_back(v);
    end else begin
      start4 = 1'b1; a4 = v.a; b4 = v.b; sub4 = v.sub; q4.push_back(v);
    end
    tick();
    start1 = 1'b0;
    start4 = 1'b0;
    cyc = 0;
    bc  = 0;
    while (!(one ? done1 : done4) && cyc < 40) begin
      if (one ? busy1 : busy4) bc++;
      tick();
      cyc++;
    end
    chk("latency", 32'(cyc), 32'(nb));
    chk("busy_cycles", 32'(bc), 32'(nb));
    tick();
    chk("done_pulse", 32'(one ? done1 : done4), 32'd0);
  endtask

  task automatic wait_done4();
    int n;
    n = 0;
    while (!done4 && n < 40) begin
      tick();
      n++;
    end
    chk("wait_done4", 32'(done4), 32'd1);
  endtask

  task automatic count_dones4(input string name);
    int n;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done4) n++;
    end
    chk(name, 32'(n), 32'd0);
  endtask

  task automatic chk_zero4(input string tag);
    chk({tag, "_busy"}, 32'(busy4), 32'd0);
    chk({tag, "_done"}, 32'(done4), 32'd0);
    chk({tag, "_res"}, res4, 32'd0);
    chk({tag, "_cout"}, 32'(cout4), 32'd0);
    chk({tag, "_ovf"}, 32'(ovf4), 32'd0);
    chk({tag, "_zero"}, 32'(zero4), 32'd0);
  endtask

  initial begin
    //                sub  a             b             result        co ov z
    t4[0] = '{1'b0, 32'h0000_0008, 32'h0000_0050, 32'h0000_0058, 1'b0, 1'b0, 1'b0};
    t4[1] = '{1'b0, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 1'b0, 1'b0, 1'b0};
    t4[2] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    t4[3] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    t4[4] = '{1'b1, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    t4[5] = '{1'b1, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    t4[6] = '{1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    t1[0] = '{1'b0, 32'd208, 32'd52, 32'h04, 1'b1, 1'b0, 1'b0};
    t1[1] = '{1'b0, 32'd80,  32'd80, 32'hA0, 1'b0, 1'b1, 1'b0};
    t1[2] = '{1'b1, 32'h00,  32'h01, 32'hFF, 1'b0, 1'b0, 1'b0};

    reset  = 1'b1;
    start4 = 1'b0; sub4 = 1'b0; a4 = '0; b4 = '0;
    start1 = 1'b0; sub1 = 1'b0; a1 = '0; b1 = '0;
    tick();
    tick();
    chk_zero4("reset");
    chk("reset_busy1", 32'(busy1), 32'd0);
    reset = 1'b0;

    foreach (t4[i]) run_op(1'b0, t4[i]);
    foreach (t1[i]) run_op(1'b1, t1[i]);

    // A second start two cycles into a run must be dropped.
    tick();
    start4 = 1'b1; a4 = 32'h1111_1111; b4 = 32'h2222_2222; sub4 = 1'b0;
    q4.push_back('{1'b0, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 1'b0, 1'b0, 1'b0});
    tick();
    start4 = 1'b0;
    tick();
    start4 = 1'b1; a4 = 32'hFFFF_FFFF; b4 = 32'hFFFF_FFFF; sub4 = 1'b1;
    tick();
    start4 = 1'b0;
    wait_done4();
    count_dones4("ignored_start_extra_done");
    chk("ignored_start_queue", 32'(q4.size()), 32'd0);

    // Start held in the done cycle begins the next operation with no gap.
    tick();
    start4 = 1'b1; a4 = 32'h0000_0001; b4 = 32'h0000_0002; sub4 = 1'b0;
    q4.push_back('{1'b0, 32'h1, 32'h2, 32'h3, 1'b0, 1'b0, 1'b0});
    tick();
    start4 = 1'b0;
    wait_done4();
    start4 = 1'b1; a4 = 32'h0000_0010; b4 = 32'h0000_0020; sub4 = 1'b0;
    q4.push_back('{1'b0, 32'h10, 32'h20, 32'h30, 1'b0, 1'b0, 1'b0});
    chk("b2b_busy_in_done", 32'(busy4), 32'd0);
    tick();
    start4 = 1'b0;
    chk("b2b_busy_next", 32'(busy4), 32'd1);
    chk("b2b_done_next", 32'(done4), 32'd0);
    wait_done4();

    // Reset arriving while byte 2 is being processed aborts the run.
    tick();
    start4 = 1'b1; a4 = 32'h0101_0101; b4 = 32'h0101_0101; sub4 = 1'b0;
    tick();
    start4 = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_zero4("midrun_reset");
    count_dones4("midrun_reset_done");
    run_op(1'b0, t4[2]);

    chk("final_q4_empty", 32'(q4.size()), 32'd0);
    chk("final_q1_empty", 32'(q1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
